// File: rtl/div_unit_pkg.sv
// Shared definitions for the execute-stage integer divider.
//   - ALU_DIV / ALU_DIVU : 5-bit alucontrol codes decoded in E for DIV/DIVU.
//   - div_state_e        : divider FSM state encoding.
package div_unit_pkg;

  localparam logic [4:0] ALU_DIV  = 5'b01010;
  localparam logic [4:0] ALU_DIVU = 5'b01011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration (combinational).
//   rem_i  : partial remainder (always < dvs_i)
//   msb_i  : next dividend bit shifted into the remainder
//   dvs_i  : divisor magnitude
//   rem_o  : next partial remainder
//   q_o    : quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             msb_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  // Shifted remainder needs WIDTH+1 bits; one more bit catches the borrow.
  logic [WIDTH+1:0] trial;
  logic             unused_trial_top;

  assign trial = {1'b0, rem_i, msb_i} - {2'b00, dvs_i};
  // When the subtract succeeds the difference is < divisor, so bit WIDTH is 0.
  assign unused_trial_top = trial[WIDTH];

  assign q_o   = ~trial[WIDTH+1];
  assign rem_o = q_o ? trial[WIDTH-1:0] : {rem_i[WIDTH-2:0], msb_i};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit for the execute stage.
//   clk, rst        : clock, asynchronous active-high reset
//   startE          : divide instruction in E (held while stalled)
//   signedE         : 1 = DIV, 0 = DIVU
//   srcaE / srcbE   : dividend / divisor
//   cancelE         : abort (flush or exception)
//   busyE           : stall request to the hazard unit
//   readyE          : one-cycle pulse, quotE/remE valid
//   quotE / remE    : quotient (LO) / remainder (HI)
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic             signedE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             cancelE,
  output logic             busyE,
  output logic             readyE,
  output logic [WIDTH-1:0] quotE,
  output logic [WIDTH-1:0] remE
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] quot_q, quot_d;   // held results
  logic [WIDTH-1:0] remo_q, remo_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .msb_i (dvd_q[WIDTH-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // 0x80000000 negates to itself, which is the right unsigned magnitude.
  assign a_mag = (signedE && srcaE[WIDTH-1]) ? -srcaE : srcaE;
  assign b_mag = (signedE && srcbE[WIDTH-1]) ? -srcbE : srcbE;

  assign quot_fix = qneg_q ? -dvd_q : dvd_q;
  assign rem_fix  = rneg_q ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quot_d  = quot_q;
    remo_d  = remo_q;

    unique case (state_q)
      IDLE: begin
        if (startE) begin
          if (srcbE == '0) begin
            // Divide by zero: result lands in the working regs so DONE
            // can present it through the same path, with no negation.
            dvd_d   = '1;
            rem_d   = srcaE;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = DONE;
          end else begin
            dvd_d   = a_mag;
            dvs_d   = b_mag;
            rem_d   = '0;
            cnt_d   = '0;
            qneg_d  = signedE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
            rneg_d  = signedE & srcaE[WIDTH-1];
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        // startE here is the finished instruction still leaving E.
        quot_d  = quot_fix;
        remo_d  = rem_fix;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (cancelE) begin
      state_d = IDLE;
      quot_d  = quot_q;
      remo_d  = remo_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
    end
  end

  // Corrected result is shown directly in DONE so it is valid with readyE,
  // then held from quot_q/remo_q until the next completion.
  assign readyE = (state_q == DONE) && !cancelE;
  assign quotE  = readyE ? quot_fix : quot_q;
  assign remE   = readyE ? rem_fix  : remo_q;
  assign busyE  = !rst && !cancelE &&
                  (((state_q == IDLE) && startE) || (state_q == RUN));

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        startE, signedE, cancelE;
  logic [31:0] srcaE, srcbE;
  logic        busyE, readyE;
  logic [31:0] quotE, remE;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .startE(startE), .signedE(signedE),
    .srcaE(srcaE), .srcbE(srcbE), .cancelE(cancelE),
    .busyE(busyE), .readyE(readyE), .quotE(quotE), .remE(remE)
  );

  always #5 clk = ~clk;

  // Called 1 time unit after a rising edge (cycle T). Holds startE until the
  // ready cycle and returns there, startE still high (ignored in DONE).
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] q, output logic [31:0] r,
                        output int busy_cnt, output logic busy_rdy);
    startE = 1'b1; signedE = sgn; srcaE = a; srcbE = b;
    #1;
    busy_cnt = busyE ? 1 : 0;
    lat = -1; q = 'x; r = 'x; busy_rdy = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (readyE) begin
        lat = k; q = quotE; r = remE; busy_rdy = busyE;
        break;
      end
      if (busyE) busy_cnt++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; startE = 1'b1; srcaE = 32'd10; srcbE = 32'd5;
    #1;
    checks++; if (busyE !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busyE); end
    checks++; if (readyE !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", readyE); end
    checks++; if (quotE !== 32'd0) begin errors++; $display("FAIL reset_quot: got %h want 0", quotE); end
    checks++; if (remE !== 32'd0) begin errors++; $display("FAIL reset_rem: got %h want 0", remE); end
    @(posedge clk); #1;
    checks++; if (busyE !== 1'b0) begin errors++; $display("FAIL reset_busy_clk: got %b want 0", busyE); end
    startE = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_div(input string nm, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input int exp_lat,
                           input logic [31:0] eq, input logic [31:0] er);
    int lat, bc; logic [31:0] q, r; logic br;
    do_div(sgn, a, b, lat, q, r, bc, br);
    checks++; if (lat !== exp_lat) begin errors++; $display("FAIL %s_latency: got %0d want %0d", nm, lat, exp_lat); end
    checks++; if (q !== eq) begin errors++; $display("FAIL %s_quot: got %h want %h", nm, q, eq); end
    checks++; if (r !== er) begin errors++; $display("FAIL %s_rem: got %h want %h", nm, r, er); end
    checks++; if (bc !== exp_lat) begin errors++; $display("FAIL %s_busy_cycles: got %0d want %0d", nm, bc, exp_lat); end
    checks++; if (br !== 1'b0) begin errors++; $display("FAIL %s_busy_at_ready: got %b want 0", nm, br); end
    @(posedge clk); #1;
    startE = 1'b0;
    #1;
    checks++; if (readyE !== 1'b0) begin errors++; $display("FAIL %s_ready_pulse: got %b want 0", nm, readyE); end
    checks++; if (quotE !== eq || remE !== er)
      begin errors++; $display("FAIL %s_hold: got %h/%h want %h/%h", nm, quotE, remE, eq, er); end
    @(posedge clk); #1;
  endtask

  task automatic test_divu_basic;  check_div("divu_100_7", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2); endtask
  task automatic test_div_neg;     check_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF); endtask
  task automatic test_div_ovf;     check_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0); endtask
  task automatic test_divu_big;    check_div("divu_big", 1'b0, 32'h1234_5678, 32'hFFFF_FFFF, 33, 32'd0, 32'h1234_5678); endtask
  task automatic test_div_zero;    check_div("divu_zero", 1'b0, 32'd55, 32'd0, 1, 32'hFFFF_FFFF, 32'd55); endtask

  task automatic test_cancel;
    int seen = 0;
    startE = 1'b1; signedE = 1'b0; srcaE = 32'd100; srcbE = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    cancelE = 1'b1;
    #1;
    checks++; if (busyE !== 1'b0) begin errors++; $display("FAIL cancel_busy: got %b want 0", busyE); end
    @(posedge clk); #1;
    startE = 1'b0; cancelE = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (readyE || busyE) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL cancel_no_ready: got %0d active cycles want 0", seen); end
    checks++; if (quotE !== 32'hFFFF_FFFF || remE !== 32'd55)
      begin errors++; $display("FAIL cancel_hold: got %h/%h want ffffffff/00000037", quotE, remE); end
  endtask

  task automatic test_back_to_back;
    int lat, bc; logic [31:0] q, r; logic br;
    do_div(1'b0, 32'd100, 32'd7, lat, q, r, bc, br);
    checks++; if (lat !== 33 || q !== 32'd14)
      begin errors++; $display("FAIL b2b_first: got lat %0d q %h want 33/0000000e", lat, q); end
    @(posedge clk); #1;  // first cycle after DONE
    do_div(1'b0, 32'd9, 32'd3, lat, q, r, bc, br);
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", lat); end
    checks++; if (q !== 32'd3 || r !== 32'd0)
      begin errors++; $display("FAIL b2b_result: got %h/%h want 00000003/00000000", q, r); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL b2b_busy_cycles: got %0d want 33", bc); end
    @(posedge clk); #1;
    startE = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset;
    int seen = 0;
    startE = 1'b1; signedE = 1'b0; srcaE = 32'd100; srcbE = 32'd7;
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (busyE !== 1'b0 || readyE !== 1'b0)
      begin errors++; $display("FAIL arst_ctrl: got busy %b ready %b want 0/0", busyE, readyE); end
    checks++; if (quotE !== 32'd0 || remE !== 32'd0)
      begin errors++; $display("FAIL arst_data: got %h/%h want 0/0", quotE, remE); end
    @(posedge clk); #1;
    startE = 1'b0; rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (readyE || busyE) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL arst_no_ready: got %0d active cycles want 0", seen); end
  endtask

  initial begin
    rst = 1'b1; startE = 1'b0; signedE = 1'b0; cancelE = 1'b0;
    srcaE = '0; srcbE = '0;
    @(posedge clk); #1;
    test_reset;
    test_divu_basic;
    test_div_neg;
    test_div_ovf;
    test_divu_big;
    test_div_zero;
    test_cancel;
    test_back_to_back;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
